// File: rtl/game_pkg.sv
// Shared scene encodings, widths and default frame counts for the space-2433 game flow.
package game_pkg;

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned LIVES_W = 4;
  localparam int unsigned TIMER_W = 9;

  localparam int unsigned DEF_START_LIVES     = 4;
  localparam int unsigned DEF_RESPAWN_FRAMES  = 120;
  localparam int unsigned DEF_GAMEOVER_FRAMES = 300;
  localparam int unsigned DEF_HISCORE_FRAMES  = 180;

  // Screen codes double as FSM state; the top-level colour mux decodes them directly.
  typedef enum logic [2:0] {
    SCR_TITLE      = 3'd0,
    SCR_PLAY       = 3'd1,
    SCR_RESPAWN    = 3'd2,
    SCR_GAME_OVER  = 3'd3,
    SCR_HIGH_SCORE = 3'd4
  } screen_t;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; expired is high whenever the count is zero.
module frame_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               tick,
  output logic               expired
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] count_next;

  // A load takes priority over a coincident tick.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_value;
    end else if (tick && (count != '0)) begin
      count_next = count - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b1;
    end else begin
      count   <= count_next;
      expired <= (count_next == '0);
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Scene and lives sequencer: title, play, respawn, game-over and high-score flow.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned START_LIVES     = DEF_START_LIVES,
  parameter int unsigned RESPAWN_FRAMES  = DEF_RESPAWN_FRAMES,
  parameter int unsigned GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES,
  parameter int unsigned HISCORE_FRAMES  = DEF_HISCORE_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               action_pulse,
  input  logic               frame_tick,
  input  logic               ship_hit,
  input  logic [SCORE_W-1:0] score,
  output logic [2:0]         screen,
  output logic [LIVES_W-1:0] lives,
  output logic               play_enable,
  output logic               game_reset,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high
);

  screen_t            state;
  screen_t            state_next;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_expired;
  logic [LIVES_W-1:0] lives_next;
  logic [SCORE_W-1:0] high_next;
  logic               new_high_next;

  frame_timer u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tick       (frame_tick),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCR_TITLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    tmr_load      = 1'b0;
    tmr_value     = '0;
    lives_next    = lives;
    high_next     = high_score;
    new_high_next = new_high;
    case (state)
      SCR_TITLE: begin
        if (action_pulse) begin
          state_next    = SCR_PLAY;
          lives_next    = LIVES_W'(START_LIVES);
          new_high_next = 1'b0;
        end
      end
      SCR_PLAY: begin
        // game_reset marks the first PLAY cycle; a hit there belongs to the previous game.
        if (ship_hit && !game_reset) begin
          if (lives > LIVES_W'(1)) begin
            state_next = SCR_RESPAWN;
            lives_next = lives - LIVES_W'(1);
            tmr_load   = 1'b1;
            tmr_value  = TIMER_W'(RESPAWN_FRAMES);
          end else begin
            state_next = SCR_GAME_OVER;
            lives_next = '0;
            tmr_load   = 1'b1;
            tmr_value  = TIMER_W'(GAMEOVER_FRAMES);
            if (score > high_score) begin
              high_next     = score;
              new_high_next = 1'b1;
            end
          end
        end
      end
      SCR_RESPAWN: begin
        if (tmr_expired) begin
          state_next = SCR_PLAY;
        end
      end
      SCR_GAME_OVER: begin
        if (tmr_expired && action_pulse) begin
          if (new_high) begin
            state_next = SCR_HIGH_SCORE;
            tmr_load   = 1'b1;
            tmr_value  = TIMER_W'(HISCORE_FRAMES);
          end else begin
            state_next = SCR_TITLE;
          end
        end
      end
      SCR_HIGH_SCORE: begin
        if (tmr_expired || action_pulse) begin
          state_next = SCR_TITLE;
        end
      end
      default: begin
        state_next = SCR_TITLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lives       <= LIVES_W'(START_LIVES);
      play_enable <= 1'b0;
      game_reset  <= 1'b0;
      high_score  <= '0;
      new_high    <= 1'b0;
    end else begin
      lives       <= lives_next;
      play_enable <= (state_next == SCR_PLAY);
      game_reset  <= (state == SCR_TITLE) && (state_next == SCR_PLAY);
      high_score  <= high_next;
      new_high    <= new_high_next;
    end
  end

  assign screen = state;

endmodule
